// File: rtl/acc_cpu_core.sv
// acc_cpu_core: multi-cycle accumulator CPU with FETCH/DECODE/EXEC sequencing,
// an internal scratchpad, carry/zero flags with conditional jumps, and
// valid/ready handshakes on the input and output ports.
module acc_cpu_core #(
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 64,
    parameter int PC_W      = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_data,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] acc,
    output logic              halted
);

    localparam int ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_AND   = 4'd5;
    localparam logic [3:0] OP_OR    = 4'd6;
    localparam logic [3:0] OP_XOR   = 4'd7;
    localparam logic [3:0] OP_JMP   = 4'd8;
    localparam logic [3:0] OP_JZ    = 4'd9;
    localparam logic [3:0] OP_JC    = 4'd10;
    localparam logic [3:0] OP_IN    = 4'd11;
    localparam logic [3:0] OP_OUT   = 4'd12;
    localparam logic [3:0] OP_HALT  = 4'd15;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_IN_WAIT,
        S_OUT_WAIT,
        S_HALT
    } state_t;

    state_t            state_reg;
    logic [PC_W-1:0]   pc_reg;
    logic [DATA_W-1:0] acc_reg;
    logic              z_reg;
    logic              c_reg;
    logic [15:0]       ir_reg;
    logic              in_ready_reg;
    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              halted_reg;

    // Scratchpad storage; intentionally not reset so it maps onto block RAM.
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [DATA_W-1:0] mem_rdata;

    // Instruction field decode
    logic [3:0]        opcode;
    logic              imm_flag;
    logic [ADDR_W-1:0] ir_addr;
    logic [PC_W-1:0]   jump_target;
    logic [PC_W-1:0]   pc_inc;
    logic [DATA_W-1:0] imm_val;
    logic [DATA_W-1:0] operand_val;
    logic [DATA_W:0]   sum_wide;
    logic [DATA_W:0]   diff_wide;

    assign opcode      = ir_reg[15:12];
    assign imm_flag    = ir_reg[11];
    assign ir_addr     = ir_reg[ADDR_W-1:0];
    assign jump_target = ir_reg[PC_W-1:0];
    assign pc_inc      = pc_reg + PC_W'(1);

    // The 11-bit immediate is zero-extended when DATA_W is wider and
    // truncated when it is narrower.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_imm
        if (gi < 11) begin : g_bit
            assign imm_val[gi] = ir_reg[gi];
        end else begin : g_zero
            assign imm_val[gi] = 1'b0;
        end
    end

    assign operand_val = imm_flag ? imm_val : mem_rdata;
    assign sum_wide    = {1'b0, acc_reg} + {1'b0, operand_val};
    assign diff_wide   = {1'b0, acc_reg} - {1'b0, operand_val};

    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic              alu_wr;
    logic              alu_upd_z;
    logic              alu_upd_c;
    logic              take_jump;

    // ALU result and flag-update enables for the instruction held in IR
    always_comb begin
        alu_res   = acc_reg;
        alu_carry = c_reg;
        alu_wr    = 1'b0;
        alu_upd_z = 1'b0;
        alu_upd_c = 1'b0;
        case (opcode)
            OP_LOAD: begin
                alu_res   = operand_val;
                alu_wr    = 1'b1;
                alu_upd_z = 1'b1;
            end
            OP_ADD: begin
                alu_res   = sum_wide[DATA_W-1:0];
                alu_carry = sum_wide[DATA_W];
                alu_wr    = 1'b1;
                alu_upd_z = 1'b1;
                alu_upd_c = 1'b1;
            end
            OP_SUB: begin
                // The extra MSB of the difference is the borrow out
                alu_res   = diff_wide[DATA_W-1:0];
                alu_carry = diff_wide[DATA_W];
                alu_wr    = 1'b1;
                alu_upd_z = 1'b1;
                alu_upd_c = 1'b1;
            end
            OP_AND: begin
                alu_res   = acc_reg & operand_val;
                alu_wr    = 1'b1;
                alu_upd_z = 1'b1;
            end
            OP_OR: begin
                alu_res   = acc_reg | operand_val;
                alu_wr    = 1'b1;
                alu_upd_z = 1'b1;
            end
            OP_XOR: begin
                alu_res   = acc_reg ^ operand_val;
                alu_wr    = 1'b1;
                alu_upd_z = 1'b1;
            end
            default: ;
        endcase
    end

    // Branch decision from the current flags
    always_comb begin
        take_jump = 1'b0;
        case (opcode)
            OP_JMP:  take_jump = 1'b1;
            OP_JZ:   take_jump = z_reg;
            OP_JC:   take_jump = c_reg;
            default: take_jump = 1'b0;
        endcase
    end

    // Scratchpad: STORE writes in EXEC, operand read is issued in DECODE,
    // so a STORE followed by a read of the same word sees the new data.
    always_ff @(posedge clk) begin
        if (state_reg == S_EXEC && opcode == OP_STORE) begin
            mem[ir_addr] <= acc_reg;
        end
        if (state_reg == S_DECODE) begin
            mem_rdata <= mem[imem_data[ADDR_W-1:0]];
        end
    end

    // Main sequencer with registered handshake and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_FETCH;
            pc_reg        <= '0;
            acc_reg       <= '0;
            z_reg         <= 1'b0;
            c_reg         <= 1'b0;
            ir_reg        <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            halted_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    state_reg <= S_DECODE;
                end
                S_DECODE: begin
                    ir_reg    <= imem_data;
                    state_reg <= S_EXEC;
                end
                S_EXEC: begin
                    if (alu_wr) begin
                        acc_reg <= alu_res;
                    end
                    if (alu_upd_z) begin
                        z_reg <= (alu_res == '0);
                    end
                    if (alu_upd_c) begin
                        c_reg <= alu_carry;
                    end
                    case (opcode)
                        OP_IN: begin
                            in_ready_reg <= 1'b1;
                            state_reg    <= S_IN_WAIT;
                        end
                        OP_OUT: begin
                            out_valid_reg <= 1'b1;
                            out_data_reg  <= acc_reg;
                            state_reg     <= S_OUT_WAIT;
                        end
                        OP_HALT: begin
                            // pc stays on the HALT instruction
                            halted_reg <= 1'b1;
                            state_reg  <= S_HALT;
                        end
                        default: begin
                            pc_reg    <= take_jump ? jump_target : pc_inc;
                            state_reg <= S_FETCH;
                        end
                    endcase
                end
                S_IN_WAIT: begin
                    if (in_valid) begin
                        acc_reg      <= in_data;
                        z_reg        <= (in_data == '0);
                        in_ready_reg <= 1'b0;
                        pc_reg       <= pc_inc;
                        state_reg    <= S_FETCH;
                    end
                end
                S_OUT_WAIT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        pc_reg        <= pc_inc;
                        state_reg     <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state_reg <= S_HALT;
                end
                default: begin
                    state_reg <= S_FETCH;
                end
            endcase
        end
    end

    assign imem_addr = pc_reg;
    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign acc       = acc_reg;
    assign halted    = halted_reg;

endmodule

// File: tb/tb_acc_cpu_core.sv
// tb_acc_cpu_core: directed and random programs run on acc_cpu_core and
// compared, instruction by instruction, with an ISA-level reference model.
module tb_acc_cpu_core;

    localparam int DW      = 16;
    localparam int DEPTH   = 64;
    localparam int PCW     = 11;
    localparam int PC_SIZE = 1 << PCW;
    localparam longint unsigned DMOD = 64'd1 << DW;

    localparam int OP_NOP = 0, OP_LOAD = 1, OP_STORE = 2, OP_ADD = 3, OP_SUB = 4;
    localparam int OP_AND = 5, OP_OR = 6, OP_XOR = 7, OP_JMP = 8, OP_JZ = 9;
    localparam int OP_JC = 10, OP_IN = 11, OP_OUT = 12, OP_HALT = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main core (DATA_W=16)
    logic [PCW-1:0] imem_addr;
    logic [15:0]    imem_data;
    logic [DW-1:0]  in_data;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  out_data;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  acc;
    logic           halted;

    logic [15:0] rom [PC_SIZE];
    always @(posedge clk) imem_data <= rom[imem_addr];

    acc_cpu_core #(.DATA_W(DW), .MEM_DEPTH(DEPTH), .PC_W(PCW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .acc(acc), .halted(halted)
    );

    // Narrow core (DATA_W=8) with a fixed program: truncation and 8-bit carry
    logic [PCW-1:0] imem_addr8;
    logic [15:0]    imem_data8;
    logic [7:0]     in_data8 = 8'h00;
    logic           in_valid8 = 1'b0;
    logic           in_ready8;
    logic [7:0]     out_data8;
    logic           out_valid8;
    logic           out_ready8 = 1'b0;
    logic [7:0]     acc8;
    logic           halted8;

    always @(posedge clk) begin
        case (imem_addr8)
            11'd0:   imem_data8 <= 16'h19FF;  // LOAD #0x1FF -> 0xFF
            11'd1:   imem_data8 <= 16'h3801;  // ADD #1 -> 0x00, C=1
            11'd2:   imem_data8 <= 16'hA004;  // JC 4 (taken)
            11'd3:   imem_data8 <= 16'hF000;  // HALT (skipped)
            11'd4:   imem_data8 <= 16'h19AB;  // LOAD #0x1AB -> 0xAB
            default: imem_data8 <= 16'hF000;
        endcase
    end

    acc_cpu_core #(.DATA_W(8), .MEM_DEPTH(DEPTH), .PC_W(PCW)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr8), .imem_data(imem_data8),
        .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
        .out_data(out_data8), .out_valid(out_valid8), .out_ready(out_ready8),
        .acc(acc8), .halted(halted8)
    );

    int checks = 0;
    int errors = 0;
    int outs   = 0;
    int wp     = 0;

    // Reference model state (ISA level)
    longint unsigned m_pc, m_acc;
    bit              m_z, m_c;
    longint unsigned m_mem [DEPTH];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic emit(input int op, input int imm, input int opr);
        rom[wp] = {op[3:0], imm[0], opr[10:0]};
        wp++;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < PC_SIZE; i++) rom[i] = 16'hF000;
        wp = 0;
    endtask

    task automatic model_reset();
        m_pc  = 0;
        m_acc = 0;
        m_z   = 1'b0;
        m_c   = 1'b0;
    endtask

    // Executes one non-I/O instruction on the model
    task automatic model_exec(input logic [15:0] ins);
        longint unsigned op, opr, val, nxt, sum;
        op  = 64'(ins[15:12]);
        opr = 64'(ins[10:0]);
        val = ins[11] ? (opr % DMOD) : m_mem[opr % DEPTH];
        nxt = (m_pc + 1) % PC_SIZE;
        case (op)
            OP_LOAD:  begin m_acc = val; m_z = (m_acc == 0); end
            OP_STORE: m_mem[opr % DEPTH] = m_acc;
            OP_ADD: begin
                sum   = m_acc + val;
                m_c   = (sum >= DMOD);
                m_acc = sum % DMOD;
                m_z   = (m_acc == 0);
            end
            OP_SUB: begin
                m_c   = (m_acc < val);
                m_acc = (m_acc + DMOD - val) % DMOD;
                m_z   = (m_acc == 0);
            end
            OP_AND: begin m_acc = m_acc & val; m_z = (m_acc == 0); end
            OP_OR:  begin m_acc = m_acc | val; m_z = (m_acc == 0); end
            OP_XOR: begin m_acc = m_acc ^ val; m_z = (m_acc == 0); end
            OP_JMP: nxt = opr % PC_SIZE;
            OP_JZ:  if (m_z) nxt = opr % PC_SIZE;
            OP_JC:  if (m_c) nxt = opr % PC_SIZE;
            default: ;
        endcase
        m_pc = nxt;
    endtask

    task automatic drive_junk();
        in_valid  = 1'($urandom_range(0, 1));
        in_data   = DW'($urandom);
        out_ready = 1'($urandom_range(0, 1));
    endtask

    // Reset pulse; returns at the sample point of the first FETCH cycle
    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check_val("rst_imem_addr", 64'(imem_addr), 64'd0);
        check_val("rst_acc", 64'(acc), 64'd0);
        check_val("rst_io", 64'({in_ready, out_valid, out_data}), 64'd0);
        check_val("rst_halted", 64'(halted), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Runs the program in rom from pc 0 until the model executes HALT.
    // in_delay/out_delay < 0 pick a random partner delay per transfer.
    task automatic run_program(input int max_instr, input bit reset_on_out,
                               input int in_delay, input int out_delay);
        int  n;
        bit  done;
        bit  did_reset;
        int  d;
        int  cnt;
        logic [15:0] ins;
        logic [DW-1:0] v;
        longint unsigned op;
        n = 0;
        done = 1'b0;
        did_reset = 1'b0;
        while (!done) begin
            if (n >= max_instr) begin
                check_val("instr_budget", 64'(n), 64'(max_instr - 1));
                break;
            end
            n++;
            check_val("fetch_pc", 64'(imem_addr), 64'(m_pc));
            check_val("fetch_acc", 64'(acc), 64'(m_acc));
            check_val("fetch_idle", 64'({halted, in_ready, out_valid}), 64'd0);
            ins = rom[m_pc];
            op  = 64'(ins[15:12]);
            drive_junk();
            @(negedge clk);
            check_val("decode_pc_hold", 64'(imem_addr), 64'(m_pc));
            drive_junk();
            @(negedge clk);
            drive_junk();
            @(negedge clk);
            if (op == OP_IN) begin
                d = (in_delay < 0) ? int'($urandom_range(0, 3)) : in_delay;
                v = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
                cnt = 0;
                for (int k = 0; k <= d; k++) begin
                    if (in_ready) cnt++;
                    in_valid  = (k == d);
                    in_data   = (k == d) ? v : DW'($urandom);
                    out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                in_valid = 1'b0;
                check_val("in_ready_cycles", 64'(cnt), 64'(d + 1));
                check_val("in_ready_drop", 64'(in_ready), 64'd0);
                $display("IN  pc=%0d data=0x%0h wait=%0d", m_pc, v, d);
                m_acc = 64'(v);
                m_z   = (v == '0);
                m_pc  = (m_pc + 1) % PC_SIZE;
            end else if (op == OP_OUT && reset_on_out && !did_reset) begin
                check_val("out_valid_before_rst", 64'(out_valid), 64'd1);
                rst_n = 1'b0;
                #1;
                check_val("out_valid_async_drop", 64'(out_valid), 64'd0);
                check_val("rst_mid_out_io", 64'({in_ready, out_data}), 64'd0);
                in_valid  = 1'b0;
                out_ready = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                model_reset();
                did_reset = 1'b1;
            end else if (op == OP_OUT) begin
                d = (out_delay < 0) ? int'($urandom_range(0, 3)) : out_delay;
                cnt = 0;
                for (int k = 0; k <= d; k++) begin
                    if (out_valid) cnt++;
                    check_val("out_data", 64'(out_data), 64'(m_acc));
                    out_ready = (k == d);
                    in_valid  = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                out_ready = 1'b0;
                check_val("out_valid_cycles", 64'(cnt), 64'(d + 1));
                check_val("out_valid_drop", 64'(out_valid), 64'd0);
                $display("OUT pc=%0d data=0x%0h wait=%0d", m_pc, m_acc, d);
                outs++;
                m_pc = (m_pc + 1) % PC_SIZE;
            end else if (op == OP_HALT) begin
                check_val("halted_set", 64'(halted), 64'd1);
                for (int k = 0; k < 20; k++) begin
                    drive_junk();
                    @(negedge clk);
                    check_val("halt_addr_frozen", 64'(imem_addr), 64'(m_pc));
                end
                check_val("halted_hold", 64'(halted), 64'd1);
                done = 1'b1;
            end else begin
                model_exec(ins);
            end
        end
    endtask

    initial begin
        int loop_pc;
        int len;
        int op;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Phase A: narrow core runs its fixed program; main core halts at 0
        clear_rom();
        do_reset();
        repeat (3) @(negedge clk);
        check_val("w8_trunc_acc", 64'(acc8), 64'h0FF);
        repeat (15) @(negedge clk);
        check_val("w8_carry_jump_acc", 64'(acc8), 64'h0AB);
        check_val("w8_halted", 64'(halted8), 64'd1);
        check_val("w8_io_idle", 64'({in_ready8, out_valid8, out_data8}), 64'd0);
        check_val("halt_at_zero", 64'({halted, imem_addr}), 64'({1'b1, 11'd0}));

        // Phase B: scratchpad init, ALU/flags, store-load, countdown loop, I/O
        clear_rom();
        for (int a = 0; a < DEPTH; a++) begin
            emit(OP_LOAD, 1, int'($urandom_range(0, 2047)));
            emit(OP_STORE, 0, a);
        end
        for (int a = 0; a < DEPTH; a++) m_mem[a] = 0;
        emit(OP_LOAD, 1, 'h7FF); emit(OP_ADD, 1, 1);
        emit(OP_JC, 0, wp + 2);  emit(OP_LOAD, 1, 'h111);
        emit(OP_LOAD, 1, 0);     emit(OP_SUB, 1, 1);
        emit(OP_JC, 0, wp + 2);  emit(OP_LOAD, 1, 'h222);
        emit(OP_STORE, 0, 9);    emit(OP_XOR, 0, 9);
        emit(OP_JZ, 0, wp + 2);  emit(OP_LOAD, 1, 'h333);
        emit(OP_LOAD, 1, 5);     emit(OP_STORE, 0, 3);
        emit(OP_LOAD, 0, 3);     emit(OP_LOAD, 1, 0);
        emit(OP_ADD, 0, 3);      emit(OP_ADD, 0, 'h7C3);
        emit(OP_LOAD, 1, 3);     emit(OP_STORE, 0, 0);
        loop_pc = wp;
        emit(OP_LOAD, 0, 0);     emit(OP_SUB, 1, 1);
        emit(OP_STORE, 0, 0);    emit(OP_OUT, 0, 0);
        emit(OP_JZ, 0, loop_pc + 6);
        emit(OP_JMP, 0, loop_pc);
        emit(OP_IN, 0, 0);       emit(OP_OUT, 0, 0);
        emit(OP_OR, 1, 'h0F0);   emit(OP_AND, 1, 'h0FF);
        emit(13, 0, 0);          emit(14, 1, 5);
        emit(OP_NOP, 0, 0);      emit(OP_HALT, 0, 0);
        do_reset();
        outs = 0;
        run_program(400, 1'b0, 5, 0);
        check_val("loop_out_count", 64'(outs), 64'd4);

        // Phase C: ten straight-line ALU instructions
        clear_rom();
        for (int i = 0; i < 10; i++) begin
            op = (i % 2 == 0) ? int'($urandom_range(OP_ADD, OP_XOR)) : OP_LOAD;
            emit(op, 1, int'($urandom_range(0, 2047)));
        end
        emit(OP_HALT, 0, 0);
        do_reset();
        run_program(20, 1'b0, -1, -1);

        // Phase D: pc wraps from 2^PC_W-1 to 0
        clear_rom();
        rom[0]         = {4'(OP_JZ), 1'b0, 11'd5};
        rom[1]         = {4'(OP_LOAD), 1'b1, 11'd0};
        rom[2]         = {4'(OP_JMP), 1'b0, 11'd2047};
        rom[PC_SIZE-1] = 16'h0000;
        do_reset();
        run_program(10, 1'b0, -1, -1);

        // Phase E: reset asserted while waiting in OUT
        clear_rom();
        emit(OP_LOAD, 1, 'h123); emit(OP_OUT, 0, 0); emit(OP_HALT, 0, 0);
        do_reset();
        run_program(10, 1'b1, -1, 0);

        // Phase F: random forward-branching programs
        for (int p = 0; p < 8; p++) begin
            clear_rom();
            len = 24;
            for (int i = 0; i < len; i++) begin
                op = int'($urandom_range(0, 14));
                if (op == OP_JMP || op == OP_JZ || op == OP_JC)
                    emit(op, int'($urandom_range(0, 1)), int'($urandom_range(i + 1, len)));
                else
                    emit(op, int'($urandom_range(0, 1)), int'($urandom_range(0, 2047)));
            end
            emit(OP_HALT, 0, 0);
            do_reset();
            run_program(len + 2, 1'b0, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
